// File: rtl/serial_subtractor.sv
// Bit-serial A - B, one bit per clock LSB first, behind a start/done handshake.
// Result and final borrow are registered and held until the next operation completes.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] sa_q, sb_q, sd_q, diff_q;
   logic [CNT_W-1:0] cnt_q;
   logic             br_q, borrow_q, busy_q, done_q;
   logic             bit_d, br_d;

   // Full-subtractor cell: the adder's sum/carry structure with the minuend inverted for the borrow.
   assign bit_d = sa_q[0] ^ sb_q[0] ^ br_q;
   assign br_d  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);

   // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         sa_q     <= '0;
         sb_q     <= '0;
         sd_q     <= '0;
         diff_q   <= '0;
         cnt_q    <= '0;
         br_q     <= 1'b0;
         borrow_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  sa_q    <= a;
                  sb_q    <= b;
                  sd_q    <= '0;
                  br_q    <= 1'b0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               sd_q  <= {bit_d, sd_q[WIDTH-1:1]};
               sa_q  <= sa_q >> 1;
               sb_q  <= sb_q >> 1;
               br_q  <= br_d;
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == LAST_BIT) begin
                  busy_q  <= 1'b0;
                  state_q <= DONE;
               end
            end
            DONE: begin
               diff_q   <= sd_q;
               borrow_q <= br_q;
               done_q   <= 1'b1;
               state_q  <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign diff       = diff_q;
   assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: an 8-bit instance for protocol/timing scenarios
// and a 4-bit instance swept over every operand pair.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] a = '0, b = '0;
   logic       busy, done, borrow_out;
   logic [7:0] diff;

   logic       start4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       busy4, done4, borrow4;
   logic [3:0] diff4;

   int total = 0;
   int bad = 0;
   int overlap = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
   );

   serial_subtractor #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .diff(diff4), .borrow_out(borrow4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
      if (busy && done) overlap++;
   endtask

   // Pulses start for one accepting edge, then waits (bounded) for done.
   task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                         output int lat, output int bcnt, output logic seen);
      a = av;
      b = bv;
      start = 1'b1;
      tick();
      start = 1'b0;
      lat = 0;
      bcnt = busy ? 1 : 0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         lat++;
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy) bcnt++;
      end
   endtask

   task automatic test_reset();
      #3;
      total++;
      if ({busy, done, borrow_out, diff} !== 11'h000) begin
         bad++;
         $display("FAIL reset_w8: got busy=%b done=%b borrow=%b diff=%h, expected all 0",
                  busy, done, borrow_out, diff);
      end
      total++;
      if ({busy4, done4, borrow4, diff4} !== 7'h00) begin
         bad++;
         $display("FAIL reset_w4: got busy=%b done=%b borrow=%b diff=%h, expected all 0",
                  busy4, done4, borrow4, diff4);
      end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int lat, bcnt;
      logic seen;
      run_op(8'h37, 8'h12, lat, bcnt, seen);
      total++;
      if (!seen || lat != 9) begin
         bad++;
         $display("FAIL basic_latency: got %0d (seen=%b), expected 9", lat, seen);
      end
      total++;
      if (bcnt != 8) begin
         bad++;
         $display("FAIL basic_busy_cycles: got %0d, expected 8", bcnt);
      end
      total++;
      if (diff !== 8'h25 || borrow_out !== 1'b0) begin
         bad++;
         $display("FAIL basic_result: got %h/%b, expected 25/0", diff, borrow_out);
      end
      tick();
      total++;
      if (done !== 1'b0 || diff !== 8'h25) begin
         bad++;
         $display("FAIL basic_pulse_hold: got done=%b diff=%h, expected done=0 diff=25", done, diff);
      end
   endtask

   task automatic test_vectors();
      logic [7:0] va[3] = '{8'h12, 8'h00, 8'hFF};
      logic [7:0] vb[3] = '{8'h37, 8'h01, 8'hFF};
      logic [7:0] vd[3] = '{8'hDB, 8'hFF, 8'h00};
      logic       vbo[3] = '{1'b1, 1'b1, 1'b0};
      int lat, bcnt;
      logic seen;
      for (int i = 0; i < 3; i++) begin
         run_op(va[i], vb[i], lat, bcnt, seen);
         total++;
         if (!seen || diff !== vd[i] || borrow_out !== vbo[i]) begin
            bad++;
            $display("FAIL vector_%0d: got %h/%b (seen=%b), expected %h/%b",
                     i, diff, borrow_out, seen, vd[i], vbo[i]);
         end
      end
   endtask

   task automatic test_ignore_start();
      int dones = 0;
      logic [7:0] d_at = '0;
      logic bo_at = 1'b0;
      a = 8'h80;
      b = 8'h01;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      a = 8'h00;
      b = 8'hFF;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done) begin
            dones++;
            d_at = diff;
            bo_at = borrow_out;
         end
      end
      total++;
      if (dones != 1) begin
         bad++;
         $display("FAIL ignore_done_count: got %0d, expected 1", dones);
      end
      total++;
      if (d_at !== 8'h7F || bo_at !== 1'b0) begin
         bad++;
         $display("FAIL ignore_result: got %h/%b, expected 7f/0", d_at, bo_at);
      end
   endtask

   task automatic test_back_to_back();
      int cyc = 0, first = -1, second = -1;
      logic [7:0] d1 = '0, d2 = '0;
      logic b1 = 1'b0, b2 = 1'b0;
      a = 8'h05;
      b = 8'h03;
      start = 1'b1;
      tick();
      a = 8'h03;
      b = 8'h05;
      for (int i = 0; i < 60; i++) begin
         tick();
         cyc++;
         if (done) begin
            if (first < 0) begin
               first = cyc; d1 = diff; b1 = borrow_out;
            end else begin
               second = cyc; d2 = diff; b2 = borrow_out;
               start = 1'b0;
               break;
            end
         end
      end
      start = 1'b0;
      total++;
      if (first < 0 || d1 !== 8'h02 || b1 !== 1'b0) begin
         bad++;
         $display("FAIL b2b_first: got %h/%b (cycle %0d), expected 02/0", d1, b1, first);
      end
      total++;
      if (second < 0 || d2 !== 8'hFE || b2 !== 1'b1) begin
         bad++;
         $display("FAIL b2b_second: got %h/%b (cycle %0d), expected fe/1", d2, b2, second);
      end
      total++;
      if (second - first != 10) begin
         bad++;
         $display("FAIL b2b_interval: got %0d, expected 10", second - first);
      end
      tick();
      tick();
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL b2b_no_third: got busy=%b, expected 0", busy);
      end
   endtask

   task automatic test_reset_mid();
      int lat, bcnt;
      logic seen;
      run_op(8'h37, 8'h12, lat, bcnt, seen);
      total++;
      if (diff !== 8'h25 || borrow_out !== 1'b0) begin
         bad++;
         $display("FAIL rst_pre_result: got %h/%b, expected 25/0", diff, borrow_out);
      end
      a = 8'hAA;
      b = 8'h55;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (busy !== 1'b0 || diff !== 8'h00 || borrow_out !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL rst_immediate: got busy=%b diff=%h borrow=%b done=%b, expected 0/00/0/0",
                  busy, diff, borrow_out, done);
      end
      tick();
      tick();
      rst_n = 1'b1;
      begin
         int dones = 0;
         for (int i = 0; i < 12; i++) begin
            tick();
            if (done) dones++;
         end
         total++;
         if (dones != 0) begin
            bad++;
            $display("FAIL rst_no_done: got %0d pulses, expected 0", dones);
         end
      end
      run_op(8'h10, 8'h01, lat, bcnt, seen);
      total++;
      if (!seen || lat != 9 || diff !== 8'h0F || borrow_out !== 1'b0) begin
         bad++;
         $display("FAIL rst_after: got %h/%b lat=%0d, expected 0f/0 lat=9", diff, borrow_out, lat);
      end
   endtask

   task automatic test_exhaustive4();
      logic [3:0] exp_d;
      logic       exp_b;
      logic       seen;
      for (int ai = 0; ai < 16; ai++) begin
         for (int bi = 0; bi < 16; bi++) begin
            a4 = 4'(ai);
            b4 = 4'(bi);
            exp_d = 4'((ai - bi) & 15);
            exp_b = (ai < bi);
            start4 = 1'b1;
            tick();
            start4 = 1'b0;
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
               tick();
               if (done4) begin
                  seen = 1'b1;
                  break;
               end
            end
            total++;
            if (!seen || diff4 !== exp_d || borrow4 !== exp_b) begin
               bad++;
               $display("FAIL w4_%0d_%0d: got %h/%b (seen=%b), expected %h/%b",
                        ai, bi, diff4, borrow4, seen, exp_d, exp_b);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_vectors();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      test_exhaustive4();
      total++;
      if (overlap != 0) begin
         bad++;
         $display("FAIL busy_done_overlap: got %0d cycles, expected 0", overlap);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
